// File: rtl/ram_master.sv
// Bus-master sequencer for the single-port simpleCPU RAM: single-word writes
// with a setup/strobe/hold WE pulse and burst reads returned as a response stream.
module ram_master #(
  parameter int AddrSize = 11,
  parameter int WordSize = 9,
  parameter int LenSize  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [AddrSize-1:0] req_addr,
  input  logic [LenSize-1:0]  req_len,
  input  logic [WordSize-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [WordSize-1:0] rsp_data,
  output logic                rsp_last,
  output logic                wr_done,
  output logic [AddrSize-1:0] ram_addr,
  output logic [WordSize-1:0] ram_di,
  output logic                ram_en,
  output logic                ram_we,
  output logic                ram_re,
  input  logic [WordSize-1:0] ram_do
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] W_SETUP  = 3'd1;
  localparam logic [2:0] W_STROBE = 3'd2;
  localparam logic [2:0] W_HOLD   = 3'd3;
  localparam logic [2:0] R_ISSUE  = 3'd4;
  localparam logic [2:0] R_DRAIN  = 3'd5;

  logic [2:0]          r_state;
  logic [LenSize-1:0]  r_count;
  logic                r_reqReady;
  logic                r_beatAvail;
  logic                r_lastAvail;
  logic                r_rspValid;
  logic                r_rspLast;
  logic [WordSize-1:0] r_rspData;
  logic                r_wrDone;
  logic [AddrSize-1:0] r_ramAddr;
  logic [WordSize-1:0] r_ramDi;
  logic                r_ramEn;
  logic                r_ramWe;
  logic                r_ramRe;

  // The RAM returns data one cycle after an issue; r_beatAvail marks that
  // cycle so ram_do is captured into rsp_data on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beatAvail <= 1'b0;
      r_lastAvail <= 1'b0;
      r_rspValid  <= 1'b0;
      r_rspLast   <= 1'b0;
      r_rspData   <= '0;
    end else begin
      r_beatAvail <= (r_state == R_ISSUE);
      r_lastAvail <= (r_state == R_ISSUE) && (r_count == '0);
      r_rspValid  <= r_beatAvail;
      r_rspLast   <= r_lastAvail;
      if (r_beatAvail) begin
        r_rspData <= ram_do;
      end
    end
  end

  // Sequencer: address and data are set up one cycle before the WE pulse and
  // held one cycle after it, since the RAM write is level-sensitive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_reqReady <= 1'b0;
      r_wrDone   <= 1'b0;
      r_ramAddr  <= '0;
      r_ramDi    <= '0;
      r_ramEn    <= 1'b0;
      r_ramWe    <= 1'b0;
      r_ramRe    <= 1'b1;
    end else begin
      r_wrDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_reqReady && req_valid) begin
            r_reqReady <= 1'b0;
            r_ramAddr  <= req_addr;
            if (req_write) begin
              r_ramDi <= req_wdata;
              r_state <= W_SETUP;
            end else begin
              r_count <= req_len;
              r_ramEn <= 1'b1;
              r_state <= R_ISSUE;
            end
          end else begin
            r_reqReady <= 1'b1;
          end
        end
        W_SETUP: begin
          r_ramEn <= 1'b1;
          r_ramWe <= 1'b1;
          r_ramRe <= 1'b0;
          r_state <= W_STROBE;
        end
        W_STROBE: begin
          r_ramEn  <= 1'b0;
          r_ramWe  <= 1'b0;
          r_ramRe  <= 1'b1;
          r_wrDone <= 1'b1;
          r_state  <= W_HOLD;
        end
        W_HOLD: begin
          r_reqReady <= 1'b1;
          r_state    <= IDLE;
        end
        R_ISSUE: begin
          if (r_count == '0) begin
            r_ramEn <= 1'b0;
            r_state <= R_DRAIN;
          end else begin
            r_ramAddr <= r_ramAddr + 1'b1;
            r_count   <= r_count - 1'b1;
          end
        end
        R_DRAIN: begin
          // The final beat is on the outputs this cycle; free the bus next.
          if (r_rspLast) begin
            r_reqReady <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_ramEn <= 1'b0;
          r_ramWe <= 1'b0;
          r_ramRe <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_reqReady;
  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;
  assign rsp_last  = r_rspLast;
  assign wr_done   = r_wrDone;
  assign ram_addr  = r_ramAddr;
  assign ram_di    = r_ramDi;
  assign ram_en    = r_ramEn;
  assign ram_we    = r_ramWe;
  assign ram_re    = r_ramRe;

endmodule

// File: tb/tb_ram_master.sv
// Testbench for ram_master: behavioural RAM plus a timeline/shadow-memory
// reference model, directed scenarios followed by randomized traffic.
module tb_ram_master;

  localparam int AW = 11;
  localparam int DW = 9;
  localparam int LW = 4;
  localparam int Depth = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reqValid = 1'b0;
  logic          reqWrite = 1'b0;
  logic [AW-1:0] reqAddr = '0;
  logic [LW-1:0] reqLen = '0;
  logic [DW-1:0] reqWdata = '0;
  logic          reqReady;
  logic          rspValid;
  logic [DW-1:0] rspData;
  logic          rspLast;
  logic          wrDone;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramDi;
  logic          ramEn;
  logic          ramWe;
  logic          ramRe;
  logic [DW-1:0] ramDo = '0;

  logic [DW-1:0] ramMem [0:Depth-1] = '{default: '0};
  logic [DW-1:0] shadow [0:Depth-1] = '{default: '0};

  int assertCount = 0;
  int failCount = 0;

  logic          prevWe = 1'b0;
  logic [AW-1:0] prevAddr = '0;
  logic [DW-1:0] prevDi = '0;

  always #5 clk = ~clk;

  ram_master #(.AddrSize(AW), .WordSize(DW), .LenSize(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
    .req_addr(reqAddr), .req_len(reqLen), .req_wdata(reqWdata),
    .rsp_valid(rspValid), .rsp_data(rspData), .rsp_last(rspLast),
    .wr_done(wrDone),
    .ram_addr(ramAddr), .ram_di(ramDi), .ram_en(ramEn), .ram_we(ramWe),
    .ram_re(ramRe), .ram_do(ramDo)
  );

  // simpleCPU RAM: write when enabled with WE, registered read otherwise.
  always @(posedge clk) begin
    if (ramEn && ramWe) ramMem[ramAddr] <= ramDi;
    else if (ramEn && ramRe) ramDo <= ramMem[ramAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Strobe invariants and write stability, sampled mid-cycle.
  always @(negedge clk) begin
    checkOutput("strobe we!=re", {31'd0, ramWe ^ ramRe}, 32'd1);
    if (rspValid || wrDone) checkOutput("rsp/wrDone overlap", {31'd0, rspValid & wrDone}, 32'd0);
    if (!rst && (ramWe || prevWe)) begin
      checkOutput("we addr stable", {21'd0, ramAddr}, {21'd0, prevAddr});
      checkOutput("we di stable", {23'd0, ramDi}, {23'd0, prevDi});
    end
    prevWe = ramWe;
    prevAddr = ramAddr;
    prevDi = ramDi;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit write, input int addr, input int len,
                               input int wdata, input bit holdValid);
    int budget = 100;
    while (!reqReady && budget > 0) begin
      step();
      budget--;
    end
    checkOutput("reqReady wait", {31'd0, reqReady}, 32'd1);
    reqValid = 1'b1;
    reqWrite = write;
    reqAddr = AW'(addr);
    reqLen = LW'(len);
    reqWdata = DW'(wdata);
    step();
    if (!holdValid) reqValid = 1'b0;
  endtask

  // Called in cycle 1 after acceptance; ends in cycle 4 (ready again).
  task automatic checkWrite(input int a, input int d);
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("wr c%0d en", c), {31'd0, ramEn}, (c == 2) ? 32'd1 : 32'd0);
      checkOutput($sformatf("wr c%0d we", c), {31'd0, ramWe}, (c == 2) ? 32'd1 : 32'd0);
      checkOutput($sformatf("wr c%0d re", c), {31'd0, ramRe}, (c == 2) ? 32'd0 : 32'd1);
      checkOutput($sformatf("wr c%0d wrDone", c), {31'd0, wrDone}, (c == 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("wr c%0d ready", c), {31'd0, reqReady}, (c == 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("wr c%0d rspValid", c), {31'd0, rspValid}, 32'd0);
      if (c <= 3) begin
        checkOutput($sformatf("wr c%0d addr", c), {21'd0, ramAddr}, 32'(a));
        checkOutput($sformatf("wr c%0d di", c), {23'd0, ramDi}, 32'(d));
      end
      if (c < 4) step();
    end
    shadow[a] = DW'(d);
  endtask

  // Called in cycle 1 after acceptance; runs to cycle N+3 or stopAt if nonzero.
  task automatic checkRead(input int a, input int len, input int stopAt);
    int n = len + 1;
    int lastC = (stopAt != 0) ? stopAt : n + 3;
    for (int c = 1; c <= lastC; c++) begin
      checkOutput($sformatf("rd c%0d en", c), {31'd0, ramEn}, (c <= n) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rd c%0d re", c), {31'd0, ramRe}, 32'd1);
      checkOutput($sformatf("rd c%0d we", c), {31'd0, ramWe}, 32'd0);
      if (c <= n)
        checkOutput($sformatf("rd c%0d addr", c), {21'd0, ramAddr}, 32'((a + c - 1) % Depth));
      checkOutput($sformatf("rd c%0d rspValid", c), {31'd0, rspValid},
                  (c >= 3 && c <= n + 2) ? 32'd1 : 32'd0);
      if (c >= 3 && c <= n + 2) begin
        checkOutput($sformatf("rd c%0d data", c), {23'd0, rspData},
                    {23'd0, shadow[(a + c - 3) % Depth]});
        checkOutput($sformatf("rd c%0d last", c), {31'd0, rspLast}, (c == n + 2) ? 32'd1 : 32'd0);
      end
      checkOutput($sformatf("rd c%0d ready", c), {31'd0, reqReady}, (c == n + 3) ? 32'd1 : 32'd0);
      if (c < lastC) step();
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    checkOutput("rst en", {31'd0, ramEn}, 32'd0);
    checkOutput("rst we", {31'd0, ramWe}, 32'd0);
    checkOutput("rst re", {31'd0, ramRe}, 32'd1);
    checkOutput("rst addr", {21'd0, ramAddr}, 32'd0);
    checkOutput("rst di", {23'd0, ramDi}, 32'd0);
    checkOutput("rst ready", {31'd0, reqReady}, 32'd0);
    checkOutput("rst rspValid", {31'd0, rspValid}, 32'd0);
    checkOutput("rst rspLast", {31'd0, rspLast}, 32'd0);
    checkOutput("rst rspData", {23'd0, rspData}, 32'd0);
    checkOutput("rst wrDone", {31'd0, wrDone}, 32'd0);
    rst = 1'b0;
    checkOutput("release ready low", {31'd0, reqReady}, 32'd0);
    step();
    checkOutput("release ready high", {31'd0, reqReady}, 32'd1);

    $display("[TB] single write");
    applyStimulus(1'b1, 'h005, 0, 'h1A3, 1'b0);
    checkWrite('h005, 'h1A3);
    checkOutput("ram word 5", {23'd0, ramMem[5]}, 32'h1A3);

    $display("[TB] write then single-beat read");
    applyStimulus(1'b1, 'h010, 0, 'h0AA, 1'b0);
    checkWrite('h010, 'h0AA);
    applyStimulus(1'b0, 'h010, 0, 0, 1'b0);
    checkRead('h010, 0, 0);

    $display("[TB] wrapping burst");
    applyStimulus(1'b1, 'h7FE, 0, 'h001, 1'b0);
    checkWrite('h7FE, 'h001);
    applyStimulus(1'b1, 'h7FF, 0, 'h002, 1'b0);
    checkWrite('h7FF, 'h002);
    applyStimulus(1'b1, 'h000, 0, 'h003, 1'b0);
    checkWrite('h000, 'h003);
    applyStimulus(1'b1, 'h001, 0, 'h004, 1'b0);
    checkWrite('h001, 'h004);
    applyStimulus(1'b0, 'h7FE, 3, 0, 1'b0);
    checkRead('h7FE, 3, 0);

    $display("[TB] req_valid held through 16-beat burst");
    applyStimulus(1'b0, 'h7F8, 15, 0, 1'b1);
    checkRead('h7F8, 15, 0);
    step();
    reqValid = 1'b0;
    checkRead('h7F8, 15, 0);

    $display("[TB] reset during burst");
    applyStimulus(1'b0, 'h7FC, 7, 0, 1'b0);
    checkRead('h7FC, 7, 4);
    step();
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst en", {31'd0, ramEn}, 32'd0);
    checkOutput("midrst we", {31'd0, ramWe}, 32'd0);
    checkOutput("midrst rspValid", {31'd0, rspValid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("inrst rspValid", {31'd0, rspValid}, 32'd0);
      checkOutput("inrst ready", {31'd0, reqReady}, 32'd0);
    end
    rst = 1'b0;
    checkOutput("postrst ready low", {31'd0, reqReady}, 32'd0);
    step();
    checkOutput("postrst ready high", {31'd0, reqReady}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("postrst rspValid", {31'd0, rspValid}, 32'd0);
      checkOutput("postrst en", {31'd0, ramEn}, 32'd0);
      step();
    end

    $display("[TB] randomized traffic");
    for (int t = 0; t < 40; t++) begin
      int a = int'($urandom_range(0, Depth - 1));
      if ($urandom_range(0, 1) == 1) begin
        int d = int'($urandom_range(0, (1 << DW) - 1));
        applyStimulus(1'b1, a, 0, d, 1'b0);
        checkWrite(a, d);
      end else begin
        int len = int'($urandom_range(0, (1 << LW) - 1));
        applyStimulus(1'b0, a, len, 0, 1'b0);
        checkRead(a, len, 0);
      end
      repeat ($urandom_range(0, 2)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
